// File: rtl/uart_frame_loader.sv
// uart_frame_loader
// Unpacks received UART bytes into pairs of 4-bit grayscale pixels and writes
// them, high nibble first, into a linear frame buffer. Once the last pixel of
// the frame is written the block reports buffer_filled and ignores input until
// rearm or reset. A transfer that stalls mid-frame is resynchronised to pixel 0
// after TIMEOUT_CYCLES idle clocks.
//
// Input handshake: rx_valid is a one-cycle strobe with no back-pressure. A byte
// is taken in IDLE, and also in the WR_LO cycle so that bytes two cycles apart
// stream without a gap. A strobe in WR_HI cannot be taken; it is dropped and
// recorded in the sticky overflow flag. In FULL, strobes are ignored silently.
//
// All outputs are registered. The FSM state is exposed on dbg_state so that
// checkers can observe it.

module uart_frame_loader #(
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int ADDR_W         = 19,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rearm,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [3:0]        fb_data,
    output logic              buffer_filled,
    output logic              overflow,
    output logic              resync,
    output logic [1:0]        dbg_state
);

    localparam int TOTAL = H_RES * V_RES;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    // Pixel index of the left pixel of the final byte of the frame.
    localparam logic [ADDR_W-1:0] LAST_PAIR = ADDR_W'(TOTAL - 2);
    // Counter value at which the next idle clock completes the timeout.
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_HI = 2'd1,
        WR_LO = 2'd2,
        FULL  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pix_idx;   // left pixel of the byte being written / next byte
    logic [3:0]        hold_lo;   // low nibble of the accepted byte, written in WR_HI
    logic [TO_W-1:0]   to_cnt;    // idle clocks spent mid-frame

    assign dbg_state = state;

    // Frame loader FSM with registered write port, status flags and timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pix_idx       <= '0;
            hold_lo       <= '0;
            to_cnt        <= '0;
            fb_we         <= 1'b0;
            fb_addr       <= '0;
            fb_data       <= '0;
            buffer_filled <= 1'b0;
            overflow      <= 1'b0;
            resync        <= 1'b0;
        end else begin
            resync <= 1'b0;
            if (rearm) begin
                // Restart wins over any write in flight; a coincident strobe is lost.
                state         <= IDLE;
                pix_idx       <= '0;
                to_cnt        <= '0;
                fb_we         <= 1'b0;
                buffer_filled <= 1'b0;
                overflow      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rx_valid) begin
                            hold_lo <= rx_data[3:0];
                            fb_we   <= 1'b1;
                            fb_addr <= pix_idx;
                            fb_data <= rx_data[7:4];
                            to_cnt  <= '0;
                            state   <= WR_HI;
                        end else begin
                            fb_we <= 1'b0;
                            // Only a partially received frame can time out.
                            if (pix_idx != '0) begin
                                if (to_cnt == TO_LAST) begin
                                    pix_idx <= '0;
                                    resync  <= 1'b1;
                                    to_cnt  <= '0;
                                end else begin
                                    to_cnt <= to_cnt + 1'b1;
                                end
                            end
                        end
                    end

                    WR_HI: begin
                        fb_we   <= 1'b1;
                        fb_addr <= pix_idx + ADDR_W'(1);
                        fb_data <= hold_lo;
                        if (rx_valid) begin
                            overflow <= 1'b1;
                        end
                        state <= WR_LO;
                    end

                    WR_LO: begin
                        if (pix_idx == LAST_PAIR) begin
                            // Index is left parked on the last pair; FULL never advances it.
                            fb_we         <= 1'b0;
                            buffer_filled <= 1'b1;
                            state         <= FULL;
                        end else begin
                            pix_idx <= pix_idx + ADDR_W'(2);
                            if (rx_valid) begin
                                hold_lo <= rx_data[3:0];
                                fb_we   <= 1'b1;
                                fb_addr <= pix_idx + ADDR_W'(2);
                                fb_data <= rx_data[7:4];
                                to_cnt  <= '0;
                                state   <= WR_HI;
                            end else begin
                                fb_we <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end

                    FULL: begin
                        fb_we         <= 1'b0;
                        buffer_filled <= 1'b1;
                    end

                    default: begin
                        fb_we <= 1'b0;
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Testbench for uart_frame_loader on a small 4x2 frame with a 100-cycle timeout.
// Writes are collected by a negedge monitor; each scenario task builds its own
// expected write list and compares inline.

module tb_uart_frame_loader;

    localparam int H_RES = 4;
    localparam int V_RES = 2;
    localparam int AW    = 3;
    localparam int TOUT  = 100;
    localparam int TOTAL = H_RES * V_RES;
    localparam int W     = AW + 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rearm;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [3:0]    fb_data;
    logic          buffer_filled;
    logic          overflow;
    logic          resync;
    logic [1:0]    dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int resync_cnt;

    logic [W-1:0] obs_q[$];
    int           obs_cyc_q[$];
    logic [W-1:0] exp_q[$];

    uart_frame_loader #(
        .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(AW), .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rearm(rearm), .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data),
        .buffer_filled(buffer_filled), .overflow(overflow), .resync(resync),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: record every frame buffer write and every resync cycle
    always @(negedge clk) begin
        if (fb_we === 1'b1) begin
            obs_q.push_back({fb_addr, fb_data});
            obs_cyc_q.push_back(cyc);
        end
        if (resync === 1'b1) resync_cnt++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_cyc_q.delete();
        exp_q.delete();
        resync_cnt = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        rx_valid = 1'b0;
        rearm    = 1'b0;
        rx_data  = 8'h00;
        tick(2);
        reset = 1'b0;
        tick(1);
        clear_obs();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if ({fb_we, fb_addr, fb_data, buffer_filled, overflow, resync} !== '0) begin
            failures++;
            $display("FAIL reset_values: got we=%b addr=%0d data=%h filled=%b ovf=%b resync=%b want all 0",
                     fb_we, fb_addr, fb_data, buffer_filled, overflow, resync);
        end
    endtask

    task automatic test_single_byte();
        do_reset();
        send_byte(8'hA5);
        checks++;
        if ({fb_we, fb_addr, fb_data} !== {1'b1, 3'd0, 4'hA}) begin
            failures++;
            $display("FAIL single_hi: got we=%b addr=%0d data=%h want we=1 addr=0 data=a", fb_we, fb_addr, fb_data);
        end
        tick(1);
        checks++;
        if ({fb_we, fb_addr, fb_data} !== {1'b1, 3'd1, 4'h5}) begin
            failures++;
            $display("FAIL single_lo: got we=%b addr=%0d data=%h want we=1 addr=1 data=5", fb_we, fb_addr, fb_data);
        end
        tick(1);
        checks++;
        if (fb_we !== 1'b0 || buffer_filled !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL single_after: got we=%b filled=%b ovf=%b want 0 0 0", fb_we, buffer_filled, overflow);
        end
    endtask

    task automatic test_spacing();
        do_reset();
        send_byte(8'h12);
        tick(1);
        send_byte(8'h34);
        tick(3);
        exp_q = '{{3'd0, 4'h1}, {3'd1, 4'h2}, {3'd2, 4'h3}, {3'd3, 4'h4}};
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL spacing2_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL spacing2_write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        if (obs_cyc_q.size() == 4) begin
            checks++;
            if (obs_cyc_q[3] - obs_cyc_q[0] != 3) begin
                failures++;
                $display("FAIL spacing2_contiguous: got span %0d want 3", obs_cyc_q[3] - obs_cyc_q[0]);
            end
        end
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL spacing2_ovf: got %b want 0", overflow);
        end

        // strobes one cycle apart: second byte is dropped
        do_reset();
        send_byte(8'h12);
        send_byte(8'h34);
        tick(4);
        exp_q = '{{3'd0, 4'h1}, {3'd1, 4'h2}};
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL spacing1_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL spacing1_write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL spacing1_ovf: got %b want 1", overflow);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        // drop one byte so overflow is set and must survive the timeout
        send_byte(8'h01);
        send_byte(8'h02);
        tick(1);
        send_byte(8'h03);
        tick(2);
        send_byte(8'h04);
        resync_cnt = 0;
        tick(95);
        checks++;
        if (resync_cnt != 0) begin
            failures++;
            $display("FAIL timeout_early: got %0d resync cycles want 0", resync_cnt);
        end
        tick(15);
        checks++;
        if (resync_cnt != 1) begin
            failures++;
            $display("FAIL timeout_pulse: got %0d resync cycles want 1", resync_cnt);
        end
        checks++;
        if (overflow !== 1'b1) begin
            failures++;
            $display("FAIL timeout_ovf: got %b want 1", overflow);
        end
        clear_obs();
        send_byte(8'h7C);
        tick(3);
        exp_q = '{{3'd0, 4'h7}, {3'd1, 4'hC}};
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL timeout_next_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL timeout_next_write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_rearm();
        logic [7:0] b;
        do_reset();
        for (int k = 0; k < TOTAL / 2; k++) begin
            b = 8'($urandom);
            exp_q.push_back({AW'(2 * k), b[7:4]});
            exp_q.push_back({AW'(2 * k + 1), b[3:0]});
            if (k != 0) tick(1);
            send_byte(b);
        end
        tick(1);
        checks++;
        if (fb_we !== 1'b1 || fb_addr !== AW'(TOTAL - 1) || buffer_filled !== 1'b0) begin
            failures++;
            $display("FAIL full_last_write: got we=%b addr=%0d filled=%b want 1 %0d 0", fb_we, fb_addr, buffer_filled, TOTAL - 1);
        end
        tick(1);
        checks++;
        if (buffer_filled !== 1'b1 || fb_we !== 1'b0) begin
            failures++;
            $display("FAIL full_filled: got filled=%b we=%b want 1 0", buffer_filled, fb_we);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL full_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL full_write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        // extra byte while full is ignored quietly
        clear_obs();
        send_byte(8'hFF);
        tick(3);
        checks++;
        if (obs_q.size() != 0 || overflow !== 1'b0 || buffer_filled !== 1'b1) begin
            failures++;
            $display("FAIL full_extra: got writes=%0d ovf=%b filled=%b want 0 0 1", obs_q.size(), overflow, buffer_filled);
        end
        // rearm with a coincident strobe: strobe is lost
        rearm    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h88;
        tick(1);
        rearm    = 1'b0;
        rx_valid = 1'b0;
        checks++;
        if (buffer_filled !== 1'b0 || fb_we !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL rearm_clear: got filled=%b we=%b ovf=%b want 0 0 0", buffer_filled, fb_we, overflow);
        end
        tick(3);
        checks++;
        if (obs_q.size() != 0) begin
            failures++;
            $display("FAIL rearm_drop: got %0d writes want 0", obs_q.size());
        end
        send_byte(8'h3D);
        tick(3);
        exp_q = '{{3'd0, 4'h3}, {3'd1, 4'hD}};
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
            failures++;
            $display("FAIL rearm_next: got n=%0d first=%h want n=2 %h %h", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : {W{1'bx}}, exp_q[0], exp_q[1]);
        end
        // rearm while the high nibble is being written: no low write follows
        clear_obs();
        send_byte(8'h99);
        rearm = 1'b1;
        tick(1);
        rearm = 1'b0;
        checks++;
        if (fb_we !== 1'b0) begin
            failures++;
            $display("FAIL rearm_wrhi_we: got %b want 0", fb_we);
        end
        tick(2);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== {3'd2, 4'h9}) begin
            failures++;
            $display("FAIL rearm_wrhi_writes: got n=%0d want 1 write of %h", obs_q.size(), {3'd2, 4'h9});
        end
        clear_obs();
        send_byte(8'h56);
        tick(3);
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== {3'd0, 4'h5} || obs_q[1] !== {3'd1, 4'h6}) begin
            failures++;
            $display("FAIL rearm_wrhi_next: got n=%0d want writes 05 16 at addr 0,1", obs_q.size());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_byte(8'hB7);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({fb_we, fb_addr, fb_data, buffer_filled, overflow, resync} !== '0) begin
            failures++;
            $display("FAIL async_reset: got we=%b addr=%0d data=%h filled=%b ovf=%b resync=%b want all 0",
                     fb_we, fb_addr, fb_data, buffer_filled, overflow, resync);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick(1);
        clear_obs();
        send_byte(8'h4E);
        tick(3);
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== {3'd0, 4'h4} || obs_q[1] !== {3'd1, 4'hE}) begin
            failures++;
            $display("FAIL async_next: got n=%0d want writes 04 1e at addr 0,1", obs_q.size());
        end
    endtask

    // random byte stream against a byte-level model of acceptance
    task automatic test_random();
        int         p;
        int         last_acc;
        int         t;
        bit         full;
        bit         ovf;
        logic [7:0] b;
        do_reset();
        p        = 0;
        last_acc = -10;
        full     = 1'b0;
        ovf      = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (full && $urandom_range(0, 3) == 0) begin
                tick(3);
                rearm = 1'b1;
                tick(1);
                rearm    = 1'b0;
                p        = 0;
                full     = 1'b0;
                ovf      = 1'b0;
                last_acc = -10;
            end
            tick($urandom_range(0, 3));
            b = 8'($urandom);
            t = cyc;
            if (t == last_acc + 1) begin
                ovf = 1'b1;
            end else if (!full) begin
                exp_q.push_back({AW'(p), b[7:4]});
                exp_q.push_back({AW'(p + 1), b[3:0]});
                p        = p + 2;
                last_acc = t;
                if (p == TOTAL) full = 1'b1;
            end
            send_byte(b);
        end
        tick(4);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count: got %0d writes want %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                failures++;
                $display("FAIL random_write%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (overflow !== ovf || buffer_filled !== full) begin
            failures++;
            $display("FAIL random_flags: got ovf=%b filled=%b want ovf=%b filled=%b", overflow, buffer_filled, ovf, full);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        resync_cnt = 0;
        test_reset();
        test_single_byte();
        test_spacing();
        test_timeout();
        test_rearm();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
